bracket_gen: RTL and testbench
==============================

# bracket_gen

Sequence generator that drives the `a`/`b` handshake lines into the start-triggered bracket checker stage. On each rising edge of `start`, it emits exactly one opening `b` pulse, then one `a` pulse granted to an upstream requester, then one closing `b` pulse. The generator guarantees that `a` never coincides with `b` and that no `b` occurs between the opening `b` and the granted `a`. It is the producer side of the single-`a`-between-two-`b` protocol.

## Interface
- `PRE_GAP`, default 0: idle cycles between the detected `start` edge and the opening `b`.
- `MID_GAP`, default 0: idle cycles between the `a` pulse and the closing `b`.
- `TIMEOUT`, default 16: maximum cycles spent waiting for `req` (used only with the timeout feature); minimum 1.
- `CNT_W`, default 8: width of the completed-sequence counter.
- `clk` input 1: sole clock; all logic on posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: sequence trigger; only its rising edge is acted on.
- `req` input 1: upstream request for the single `a` slot; level-sampled.
- `a` output 1: one-cycle grant pulse, registered.
- `b` output 1: one-cycle bracket pulse (opening and closing), registered.
- `busy` output 1: high from the cycle after the edge is detected until `done`/`err`.
- `done` output 1: one-cycle pulse coincident with the closing `b`.
- `err` output 1: one-cycle pulse on timeout abort.
- `seq_cnt` output CNT_W: count of completed sequences; wraps modulo 2^CNT_W.

## Operation
- Reset (async assert, any state): `a`=`b`=`busy`=`done`=`err`=0, `seq_cnt`=0, state IDLE, previous-`start` register=0.
  - A `start` held high through reset release is not treated as an edge.
- Edge detect: rise = `start` & ~`start_q`.
- States and transitions:
  - IDLE: on rise, go to PRE if PRE_GAP>0, else to OPEN.
  - PRE: count PRE_GAP cycles, then go to OPEN.
  - OPEN: drive `b`=1 for one cycle. `req` is sampled in this cycle. If `req`=1, go to FIRE; else go to WAIT.
  - WAIT: go to FIRE when `req`=1.
  - FIRE: drive `a`=1 for one cycle. Then go to MID if MID_GAP>0, else to CLOSE.
  - MID: count MID_GAP cycles, then go to CLOSE.
  - CLOSE: drive `b`=1 and `done`=1 for one cycle; increment `seq_cnt`; return to IDLE.
- Only one `a` is issued per sequence. Extra or held `req` is ignored outside OPEN/WAIT.
- A rise while not in IDLE is ignored; it is neither queued nor restarts the sequence.
- A rise in the same cycle as CLOSE is ignored. A new sequence needs a fresh rise sampled in IDLE.
- `a` and `b` are never high in the same cycle.

## Timing
- Rise sampled at posedge k, with PRE_GAP=0: `b` is high in cycle k+1.
- `req` high when sampled at the end of OPEN: `a` is high in cycle k+2.
- Closing `b` is high in cycle k+3+MID_GAP.
- Minimum sequence (all gaps 0, `req` held high): b, a, b on three consecutive cycles.
- Each additional cycle that `req` stays low in OPEN/WAIT delays `a` by one cycle.
- `busy` is high from cycle k+1 through the closing-`b` cycle inclusive.
- `seq_cnt` updates at the posedge that ends the CLOSE cycle.

## Configuration
- `BRACKET_GEN_TIMEOUT_EN` defined:
  - A wait counter runs in OPEN and WAIT.
  - If `req` has not been seen after TIMEOUT cycles: pulse `err` for one cycle, issue no `a` and no closing `b`, return to IDLE.
  - `seq_cnt` is unchanged on an abort.
- Macro not defined: WAIT holds indefinitely, `err` is tied to 0, and no wait counter is synthesised.

## Test plan
- Reset, then `start` rises at cycle 1 with `req`=1 and gaps at 0 -> `b`@2, `a`@3, `b`+`done`@4, `seq_cnt`=1, `busy` high cycles 2–4.
- `req` held low for 5 cycles after the opening `b` -> `a` delayed by exactly 5 cycles; no `b` between the opening `b` and `a`; `a`/`b` never overlap.
- Second `start` pulse at cycle 3 during a sequence -> ignored; one sequence only; `seq_cnt`=1.
- PRE_GAP=2, MID_GAP=3 -> opening `b` at k+3, closing `b` 4 cycles after `a`.
- With `BRACKET_GEN_TIMEOUT_EN`, TIMEOUT=4, `req`=0 -> `err` pulse, no `a`, no closing `b`, `seq_cnt` unchanged, back to IDLE.
- `rst_n` low in WAIT -> all outputs 0 immediately. After release with `start` held high, no sequence starts until `start` falls and rises again.

Source files
------------

// File: rtl/bracket_gen.sv
// -----------------------------------------------------------------------------
// bracket_gen
//
// Producer for the single-`a`-between-two-`b` bracket protocol. Every rising
// edge of `start` seen while idle launches one sequence:
//   opening `b` pulse -> one `a` grant to the upstream requester -> closing `b`.
// `a` and `b` never overlap, and no `b` is issued between the opening `b` and
// the granted `a`.
//
// Parameters
//   PRE_GAP  idle cycles between the detected start edge and the opening b
//   MID_GAP  idle cycles between the a pulse and the closing b
//   TIMEOUT  max cycles spent waiting for req (timeout feature only), >= 1
//   CNT_W    width of the completed-sequence counter
//
// Ports
//   clk        sole clock, posedge
//   rst_n      asynchronous active-low reset
//   start      sequence trigger, rising edge only
//   req        upstream request for the single a slot (level)
//   a          one-cycle grant pulse (registered)
//   b          one-cycle bracket pulse, opening and closing (registered)
//   busy       high from the cycle after the edge through the closing b
//   done       one-cycle pulse coincident with the closing b
//   err        one-cycle pulse on timeout abort
//   seq_cnt    completed sequences, wraps modulo 2^CNT_W
//   dbg_state  current FSM state encoding
//
// Optional feature: define BRACKET_GEN_TIMEOUT_EN to abort a sequence when
// req is not seen within TIMEOUT cycles of OPEN/WAIT. Without it, WAIT holds
// indefinitely and err is tied low.
//
// Handshake: req is a level request from upstream and is only looked at in
// OPEN and WAIT. The grant `a` is a one-cycle pulse issued in the cycle after
// req is sampled high there; upstream holds req until it sees `a`. Exactly one
// grant is issued per sequence; req at any other time is ignored.
// -----------------------------------------------------------------------------
module bracket_gen #(
   parameter int unsigned PRE_GAP = 0,
   parameter int unsigned MID_GAP = 0,
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             req,
   output logic             a,
   output logic             b,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] seq_cnt,
   output logic [2:0]       dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PRE   = 3'd1,
      S_OPEN  = 3'd2,
      S_WAIT  = 3'd3,
      S_FIRE  = 3'd4,
      S_MID   = 3'd5,
      S_CLOSE = 3'd6
   } state_t;

   // One counter serves both gaps; PRE and MID are never active together.
   localparam int unsigned GAP_MAX = (PRE_GAP > MID_GAP) ? PRE_GAP : MID_GAP;
   localparam int unsigned GAP_W   = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;
   localparam logic [GAP_W-1:0] PRE_LAST = GAP_W'((PRE_GAP > 0) ? PRE_GAP - 1 : 0);
   localparam logic [GAP_W-1:0] MID_LAST = GAP_W'((MID_GAP > 0) ? MID_GAP - 1 : 0);

   state_t             state_q, state_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               start_q, start_d;
   logic               armed_q, armed_d;
   logic               a_q, a_d;
   logic               b_q, b_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic               rise;
   logic               abort;
   logic               wait_expired;

   // armed_q stays low after reset until start has been seen low, so a start
   // held high through reset release is not mistaken for an edge.
   assign rise = start & ~start_q & armed_q;

`ifdef BRACKET_GEN_TIMEOUT_EN
   localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   logic [WAIT_W-1:0] wait_q, wait_d;

   // Counts OPEN/WAIT cycles without req; cleared everywhere else so each
   // sequence starts from zero when it enters OPEN.
   always_comb begin
      wait_d = '0;
      if (((state_q == S_OPEN) || (state_q == S_WAIT)) && !req) begin
         wait_d = wait_q + WAIT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_q <= '0;
      end else begin
         wait_q <= wait_d;
      end
   end

   assign wait_expired = (wait_q == WAIT_LAST);
`else
   assign wait_expired = 1'b0;

   // TIMEOUT has no effect without the timeout feature.
   if (TIMEOUT == 0) begin : g_timeout_unused
   end
`endif

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      cnt_d   = cnt_q;
      start_d = start;
      armed_d = armed_q | ~start;
      abort   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (rise) begin
               gap_d   = '0;
               state_d = (PRE_GAP > 0) ? S_PRE : S_OPEN;
            end
         end
         S_PRE: begin
            if (gap_q == PRE_LAST) begin
               state_d = S_OPEN;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         S_OPEN, S_WAIT: begin
            if (req) begin
               state_d = S_FIRE;
            end else if (wait_expired) begin
               state_d = S_IDLE;
               abort   = 1'b1;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_FIRE: begin
            gap_d   = '0;
            state_d = (MID_GAP > 0) ? S_MID : S_CLOSE;
         end
         S_MID: begin
            if (gap_q == MID_LAST) begin
               state_d = S_CLOSE;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         S_CLOSE: begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they are flops that line
      // up with the state they belong to.
      a_d    = (state_d == S_FIRE);
      b_d    = (state_d == S_OPEN) || (state_d == S_CLOSE);
      done_d = (state_d == S_CLOSE);
      busy_d = (state_d != S_IDLE);
      err_d  = abort;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         gap_q   <= '0;
         cnt_q   <= '0;
         start_q <= 1'b0;
         armed_q <= 1'b0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         cnt_q   <= cnt_d;
         start_q <= start_d;
         armed_q <= armed_d;
         a_q     <= a_d;
         b_q     <= b_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign a         = a_q;
   assign b         = b_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign seq_cnt   = cnt_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_bracket_gen.sv
// -----------------------------------------------------------------------------
// tb_bracket_gen
//
// Bench for bracket_gen. Instance u_dut uses default gaps and is driven from
// a vector table (one row per cycle: inputs plus expected outputs). Instance
// u_gap (PRE_GAP=2, MID_GAP=3) and, with BRACKET_GEN_TIMEOUT_EN, instance
// u_tmo (TIMEOUT=4) are exercised by short hand-written sequences, as is the
// reset-in-WAIT case on u_dut.
// -----------------------------------------------------------------------------
module tb_bracket_gen;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic       start, req, a, b, busy, done, err;
   logic [7:0] seq_cnt;
   logic [2:0] dbg_state;

   logic       start2, req2, a2, b2, busy2, done2, err2;
   logic [7:0] seq_cnt2;
   logic [2:0] dbg_state2;

   bracket_gen u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .req(req),
      .a(a), .b(b), .busy(busy), .done(done), .err(err),
      .seq_cnt(seq_cnt), .dbg_state(dbg_state)
   );

   bracket_gen #(.PRE_GAP(2), .MID_GAP(3)) u_gap (
      .clk(clk), .rst_n(rst_n), .start(start2), .req(req2),
      .a(a2), .b(b2), .busy(busy2), .done(done2), .err(err2),
      .seq_cnt(seq_cnt2), .dbg_state(dbg_state2)
   );

`ifdef BRACKET_GEN_TIMEOUT_EN
   logic       start3, req3, a3, b3, busy3, done3, err3;
   logic [7:0] seq_cnt3;
   logic [2:0] dbg_state3;

   bracket_gen #(.TIMEOUT(4)) u_tmo (
      .clk(clk), .rst_n(rst_n), .start(start3), .req(req3),
      .a(a3), .b(b3), .busy(busy3), .done(done3), .err(err3),
      .seq_cnt(seq_cnt3), .dbg_state(dbg_state3)
   );
`endif

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic       start;
      logic       req;
      logic       a;
      logic       b;
      logic       busy;
      logic       done;
      logic [7:0] cnt;
   } vec_t;

   vec_t vq[$];

   task automatic add_vec(input logic s, input logic r, input logic ea, input logic eb,
                          input logic ebusy, input logic edone, input logic [7:0] ecnt);
      vec_t v;
      v.start = s;  v.req  = r;
      v.a     = ea; v.b    = eb;
      v.busy  = ebusy; v.done = edone;
      v.cnt   = ecnt;
      vq.push_back(v);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   // ---------------- test ----------------
   initial begin
      rst_n  = 1'b0;
      start  = 1'b0; req  = 1'b0;
      start2 = 1'b0; req2 = 1'b0;
`ifdef BRACKET_GEN_TIMEOUT_EN
      start3 = 1'b0; req3 = 1'b0;
`endif

      //        start req | a  b  busy done cnt
      // minimal sequence, req held high
      add_vec(0, 1,  0, 0, 0, 0, 8'd0);   // c0
      add_vec(1, 1,  0, 0, 0, 0, 8'd0);   // c1 rise sampled at end
      add_vec(1, 1,  0, 1, 1, 0, 8'd0);   // c2 opening b
      add_vec(0, 1,  1, 0, 1, 0, 8'd0);   // c3 a
      add_vec(0, 1,  0, 1, 1, 1, 8'd0);   // c4 closing b + done
      add_vec(0, 1,  0, 0, 0, 0, 8'd1);   // c5 count updated
      // req low for 5 cycles after the opening b
      add_vec(1, 0,  0, 0, 0, 0, 8'd1);   // c6 rise
      add_vec(0, 0,  0, 1, 1, 0, 8'd1);   // c7 opening b, req low
      add_vec(0, 0,  0, 0, 1, 0, 8'd1);   // c8
      add_vec(0, 0,  0, 0, 1, 0, 8'd1);   // c9
      add_vec(0, 0,  0, 0, 1, 0, 8'd1);   // c10
      add_vec(0, 0,  0, 0, 1, 0, 8'd1);   // c11
      add_vec(0, 1,  0, 0, 1, 0, 8'd1);   // c12 req seen in WAIT
      add_vec(0, 1,  1, 0, 1, 0, 8'd1);   // c13 a, 5 cycles late
      add_vec(0, 1,  0, 1, 1, 1, 8'd1);   // c14
      add_vec(0, 1,  0, 0, 0, 0, 8'd2);   // c15
      // second rise during FIRE is ignored
      add_vec(1, 1,  0, 0, 0, 0, 8'd2);   // c16 rise
      add_vec(0, 1,  0, 1, 1, 0, 8'd2);   // c17
      add_vec(1, 1,  1, 0, 1, 0, 8'd2);   // c18 rise in FIRE
      add_vec(0, 1,  0, 1, 1, 1, 8'd2);   // c19
      add_vec(0, 1,  0, 0, 0, 0, 8'd3);   // c20 no new sequence
      // rise coincident with CLOSE is ignored, held start does not retrigger
      add_vec(1, 1,  0, 0, 0, 0, 8'd3);   // c21 rise
      add_vec(1, 1,  0, 1, 1, 0, 8'd3);   // c22
      add_vec(0, 1,  1, 0, 1, 0, 8'd3);   // c23
      add_vec(1, 1,  0, 1, 1, 1, 8'd3);   // c24 rise in CLOSE
      add_vec(1, 1,  0, 0, 0, 0, 8'd4);   // c25
      add_vec(1, 1,  0, 0, 0, 0, 8'd4);   // c26
      add_vec(0, 0,  0, 0, 0, 0, 8'd4);   // c27

      // reset state
      @(negedge clk);
      check("rst a", a, 1'b0);
      check("rst b", b, 1'b0);
      check("rst busy", busy, 1'b0);
      check("rst done", done, 1'b0);
      check("rst err", err, 1'b0);
      check("rst seq_cnt", seq_cnt, 8'd0);
      check("rst state", dbg_state, 3'd0);
      check("rst gap b", b2, 1'b0);
      check("rst gap state", dbg_state2, 3'd0);
      @(negedge clk);
      rst_n = 1'b1;
      req   = 1'b1;

      // table-driven section
      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         check($sformatf("vec%0d a", i), a, vq[i].a);
         check($sformatf("vec%0d b", i), b, vq[i].b);
         check($sformatf("vec%0d busy", i), busy, vq[i].busy);
         check($sformatf("vec%0d done", i), done, vq[i].done);
         check($sformatf("vec%0d seq_cnt", i), seq_cnt, vq[i].cnt);
         check($sformatf("vec%0d err", i), err, 1'b0);
         check($sformatf("vec%0d a_b_overlap", i), a & b, 1'b0);
         start = vq[i].start;
         req   = vq[i].req;
      end

      // reset asserted while in WAIT, start held high through release
      @(negedge clk);
      start = 1'b1;
      req   = 1'b0;
      @(negedge clk);
      check("wait open b", b, 1'b1);
      @(negedge clk);
      check("wait busy", busy, 1'b1);
      check("wait state", dbg_state, 3'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check("async rst a", a, 1'b0);
      check("async rst b", b, 1'b0);
      check("async rst busy", busy, 1'b0);
      check("async rst done", done, 1'b0);
      check("async rst seq_cnt", seq_cnt, 8'd0);
      check("async rst state", dbg_state, 3'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("held start busy%0d", i), busy, 1'b0);
         check($sformatf("held start b%0d", i), b, 1'b0);
      end
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      check("fresh rise b", b, 1'b1);
      check("fresh rise busy", busy, 1'b1);
      start = 1'b0;
      req   = 1'b1;
      @(negedge clk);
      check("fresh rise a", a, 1'b1);
      @(negedge clk);
      check("fresh close b", b, 1'b1);
      check("fresh close done", done, 1'b1);
      @(negedge clk);
      check("fresh seq_cnt", seq_cnt, 8'd1);
      req = 1'b0;

      // PRE_GAP=2, MID_GAP=3: opening b at k+3, a at k+4, closing b at k+8
      @(negedge clk);
      start2 = 1'b1;
      req2   = 1'b1;
      for (int off = 1; off <= 10; off++) begin
         @(negedge clk);
         start2 = 1'b0;
         check($sformatf("gap k+%0d a", off), a2, (off == 4));
         check($sformatf("gap k+%0d b", off), b2, (off == 3) || (off == 8));
         check($sformatf("gap k+%0d done", off), done2, (off == 8));
         check($sformatf("gap k+%0d busy", off), busy2, (off >= 1) && (off <= 8));
         check($sformatf("gap k+%0d err", off), err2, 1'b0);
         check($sformatf("gap k+%0d seq_cnt", off), seq_cnt2, (off >= 9) ? 8'd1 : 8'd0);
      end

`ifdef BRACKET_GEN_TIMEOUT_EN
      // TIMEOUT=4, req never asserted: b at k+1, abort after k+4, err at k+5
      @(negedge clk);
      start3 = 1'b1;
      req3   = 1'b0;
      for (int off = 1; off <= 8; off++) begin
         @(negedge clk);
         start3 = 1'b0;
         check($sformatf("tmo k+%0d a", off), a3, 1'b0);
         check($sformatf("tmo k+%0d b", off), b3, (off == 1));
         check($sformatf("tmo k+%0d done", off), done3, 1'b0);
         check($sformatf("tmo k+%0d busy", off), busy3, (off >= 1) && (off <= 4));
         check($sformatf("tmo k+%0d err", off), err3, (off == 5));
         check($sformatf("tmo k+%0d seq_cnt", off), seq_cnt3, 8'd0);
      end
      check("tmo idle state", dbg_state3, 3'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
